// File: rtl/bl_pkg.sv
// ============================================================================
// Package     : bl_pkg
// Description : Shared types and constants for the backlight zone transmitter.
//               Build option BL_PARITY_EN appends an even-parity bit to every
//               zone word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bl_pkg;

  // Transmitter FSM states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    SHIFT = 3'd2,
    LATCH = 3'd3,
    DONE  = 3'd4
  } bl_state_e;

  localparam int BL_WORD_W = 8;

`ifdef BL_PARITY_EN
  localparam int BL_BITS_PER_WORD = 9;
`else
  localparam int BL_BITS_PER_WORD = 8;
`endif

  // Bit counter must reach BL_BITS_PER_WORD (up to 9), so 4 bits.
  localparam int BL_BIT_CNT_W = 4;

  localparam int BL_ZONES_DEF   = 16;
  localparam int BL_CLK_DIV_DEF = 4;

  // Even parity: XOR of all data bits.
  function automatic logic bl_even_parity(input logic [BL_WORD_W-1:0] d);
    return ^d;
  endfunction

endpackage : bl_pkg

`default_nettype wire

// File: rtl/bl_sclk_div.sv
// ============================================================================
// Module      : bl_sclk_div
// Description : SCLK divider. Each SCLK phase lasts CLK_DIV clock cycles;
//               produces the SCLK level plus one-cycle rise/fall ticks that
//               mark the edge on which the level will change. Held cleared
//               (SCLK low) whenever not enabled.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bl_sclk_div
  import bl_pkg::*;
#(
  parameter int CLK_DIV = BL_CLK_DIV_DEF
) (
  input  logic iODCK,
  input  logic iRST,
  input  logic en_i,
  output logic sclk_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int            CW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic          sclk_q;
  logic          last_w;

  assign last_w = (cnt_q == C_LAST);
  assign rise_o = en_i & ~sclk_q & last_w;
  assign fall_o = en_i &  sclk_q & last_w;
  assign sclk_o = sclk_q;

  // Phase counter 0..CLK_DIV-1; SCLK toggles each time it wraps
  always_ff @(posedge iODCK or negedge iRST) begin
    if (!iRST) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else if (!en_i) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else if (last_w) begin
      cnt_q  <= '0;
      sclk_q <= ~sclk_q;
    end else begin
      cnt_q  <= cnt_q + CW'(1);
    end
  end

endmodule : bl_sclk_div

`default_nettype wire

// File: rtl/backlight_zone_tx.sv
// ============================================================================
// Module      : backlight_zone_tx
// Description : Serialises ZONES 8-bit zone values MSB-first over an
//               SCLK/SDO/LATCH link to the LED backlight driver, then strobes
//               LATCH so all zones update together.
//               Build option BL_PARITY_EN: 9th even-parity bit per word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module backlight_zone_tx
  import bl_pkg::*;
#(
  parameter int ZONES   = BL_ZONES_DEF,
  parameter int CLK_DIV = BL_CLK_DIV_DEF
) (
  input  logic                 iODCK,
  input  logic                 iRST,
  input  logic                 iFrameStart,
  input  logic [BL_WORD_W-1:0] iBlockData,
  input  logic                 iBlockValid,
  output logic                 oBlockReady,
  output logic                 oSCLK,
  output logic                 oSDO,
  output logic                 oLATCH,
  output logic                 oBusy,
  output logic                 oFrameDone,
  output logic                 oOverrun
);

  localparam int BW = BL_BITS_PER_WORD;
  localparam int ZW = $clog2(ZONES + 1);
  localparam int LW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [BL_BIT_CNT_W-1:0] C_BIT_LAST = BL_BIT_CNT_W'(BW);
  localparam logic [ZW-1:0]           C_ZONES    = ZW'(ZONES);
  localparam logic [LW-1:0]           C_LAT_LAST = LW'(CLK_DIV - 1);

  bl_state_e               state_q;
  logic [BW-1:0]           sr_q;
  logic [BL_BIT_CNT_W-1:0] bit_cnt_q;
  logic [ZW-1:0]           zone_cnt_q;
  logic [ZW-1:0]           zone_cnt_d;
  logic [LW-1:0]           lat_cnt_q;
  logic                    ready_q;
  logic                    busy_q;
  logic                    latch_q;
  logic                    done_q;
  logic                    ovr_q;
  logic [BW-1:0]           load_d;
  logic                    div_en_w;
  logic                    sclk_w;
  logic                    rise_w;
  logic                    fall_w;

`ifdef BL_PARITY_EN
  assign load_d = {iBlockData, bl_even_parity(iBlockData)};
`else
  assign load_d = iBlockData;
`endif

  assign zone_cnt_d = zone_cnt_q + ZW'(1);
  assign div_en_w   = (state_q == SHIFT);

  bl_sclk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_div (
    .iODCK  (iODCK),
    .iRST   (iRST),
    .en_i   (div_en_w),
    .sclk_o (sclk_w),
    .rise_o (rise_w),
    .fall_o (fall_w)
  );

  // SDO is the shift-register MSB; the last bit of a word is not shifted out
  // so SDO keeps its value through WAIT/LATCH.
  assign oSCLK       = sclk_w;
  assign oSDO        = sr_q[BW-1];
  assign oBlockReady = ready_q;
  assign oBusy       = busy_q;
  assign oLATCH      = latch_q;
  assign oFrameDone  = done_q;
  assign oOverrun    = ovr_q;

  // Frame FSM with shift register, counters and registered status outputs
  always_ff @(posedge iODCK or negedge iRST) begin
    if (!iRST) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      zone_cnt_q <= '0;
      lat_cnt_q  <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      latch_q    <= 1'b0;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      if (iFrameStart && (state_q != IDLE)) begin
        ovr_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (iFrameStart) begin
            state_q    <= WAIT;
            ready_q    <= 1'b1;
            busy_q     <= 1'b1;
            ovr_q      <= 1'b0;
            zone_cnt_q <= '0;
          end
        end
        WAIT: begin
          if (iBlockValid && ready_q) begin
            sr_q      <= load_d;
            bit_cnt_q <= '0;
            ready_q   <= 1'b0;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          // bit_cnt counts delivered rising edges; a fall with all bits
          // delivered closes the word.
          if (rise_w) begin
            bit_cnt_q <= bit_cnt_q + BL_BIT_CNT_W'(1);
          end
          if (fall_w) begin
            if (bit_cnt_q == C_BIT_LAST) begin
              zone_cnt_q <= zone_cnt_d;
              if (zone_cnt_d == C_ZONES) begin
                state_q   <= LATCH;
                latch_q   <= 1'b1;
                lat_cnt_q <= '0;
              end else begin
                state_q <= WAIT;
                ready_q <= 1'b1;
              end
            end else begin
              sr_q <= {sr_q[BW-2:0], 1'b0};
            end
          end
        end
        LATCH: begin
          if (lat_cnt_q == C_LAT_LAST) begin
            latch_q <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            lat_cnt_q <= lat_cnt_q + LW'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule : backlight_zone_tx

`default_nettype wire
